// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

   typedef enum logic [2:0] {IDLE, TAG, FETCH, SEND, GUARD, DRAIN} state_t;

   localparam logic [7:0] TAG_BASE    = 8'hA0;
   localparam int         MAX_NUM_REQ = 8;
   localparam int         IDX_W       = $clog2(MAX_NUM_REQ);

   // Packet tag byte announcing which requester owns the following bytes.
   function automatic logic [7:0] tag_byte(input logic [IDX_W-1:0] idx);
      return TAG_BASE | 8'(idx);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-side signal bundle of the arbiter; slave = arbiter, master = environment.
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);

   logic [NUM_REQ-1:0]   req_valid_i;
   logic [NUM_REQ-1:0]   req_last_i;
   logic [8*NUM_REQ-1:0] req_data_i;
   logic [NUM_REQ-1:0]   req_ready_o;
   logic [NUM_REQ-1:0]   grant_o;
   logic                 uart_wr_o;
   logic [7:0]           uart_dat_o;
   logic                 uart_busy_i;
   logic                 arb_busy_o;

   modport slave (
      input  req_valid_i, req_last_i, req_data_i, uart_busy_i,
      output req_ready_o, grant_o, uart_wr_o, uart_dat_o, arb_busy_o
   );

   modport master (
      output req_valid_i, req_last_i, req_data_i, uart_busy_i,
      input  req_ready_o, grant_o, uart_wr_o, uart_dat_o, arb_busy_o
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after ptr, else lowest overall.
module rr_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx
);

   logic [NUM_REQ-1:0] upper;
   logic [NUM_REQ-1:0] sel;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_upper
      assign upper[gi] = req[gi] && (IDX_W'(gi) >= ptr);
   end

   // Wrap to the unmasked vector when nobody sits at or above the pointer.
   assign sel = (|upper) ? upper : req;
   assign gnt = sel & (~sel + NUM_REQ'(1));

   always_comb begin
      idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one byte-serial UART transmitter.
// Optional UART_ARB_TAG_EN: each grant first emits an owner tag byte (A0 | index).
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int MAX_BURST   = 16,
   parameter int GAP_TIMEOUT = 1023
) (
   input logic              sys_clk_i,
   input logic              sys_rst_n_i,
   uart_tx_arbiter_if.slave bus
);

   localparam int GW = $clog2(GAP_TIMEOUT + 1);

   state_t             state_reg, state_next;
   logic [NUM_REQ-1:0] grant_reg, grant_next;
   logic [IDX_W-1:0]   idx_reg, idx_next;
   logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [7:0]         burst_cnt_reg, burst_cnt_next;
   logic [GW-1:0]      gap_cnt_reg, gap_cnt_next;
   logic [7:0]         dat_reg, dat_next;
   logic               last_reg, last_next;
`ifdef UART_ARB_TAG_EN
   logic               tag_reg, tag_next;
`endif

   logic [NUM_REQ-1:0] rr_gnt;
   logic [IDX_W-1:0]   rr_idx;
   logic [IDX_W-1:0]   rot_ptr;
   logic [GW-1:0]      gap_inc;
   logic               valid_sel, last_sel;
   logic [7:0]         data_sel;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req (bus.req_valid_i),
      .ptr (rr_ptr_reg),
      .gnt (rr_gnt),
      .idx (rr_idx)
   );

   always_comb begin
      valid_sel = 1'b0;
      last_sel  = 1'b0;
      data_sel  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_reg[i]) begin
            valid_sel = bus.req_valid_i[i];
            last_sel  = bus.req_last_i[i];
            data_sel  = bus.req_data_i[i*8 +: 8];
         end
      end
   end

   assign rot_ptr = (idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : idx_reg + IDX_W'(1);
   assign gap_inc = gap_cnt_reg + GW'(1);

   always_comb begin
      state_next     = state_reg;
      grant_next     = grant_reg;
      idx_next       = idx_reg;
      rr_ptr_next    = rr_ptr_reg;
      burst_cnt_next = burst_cnt_reg;
      gap_cnt_next   = gap_cnt_reg;
      dat_next       = dat_reg;
      last_next      = last_reg;
`ifdef UART_ARB_TAG_EN
      tag_next       = tag_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (|bus.req_valid_i) begin
               grant_next     = rr_gnt;
               idx_next       = rr_idx;
               burst_cnt_next = '0;
               gap_cnt_next   = '0;
`ifdef UART_ARB_TAG_EN
               state_next     = TAG;
`else
               state_next     = FETCH;
`endif
            end
         end
`ifdef UART_ARB_TAG_EN
         TAG: begin
            dat_next   = tag_byte(idx_reg);
            tag_next   = 1'b1;
            state_next = SEND;
         end
`endif
         FETCH: begin
            if (valid_sel) begin
               dat_next   = data_sel;
               last_next  = last_sel;
               state_next = SEND;
               if (burst_cnt_reg != 8'hFF) burst_cnt_next = burst_cnt_reg + 8'd1;
            end else if (gap_inc == GW'(GAP_TIMEOUT)) begin
               grant_next  = '0;
               rr_ptr_next = rot_ptr;
               state_next  = IDLE;
            end else begin
               gap_cnt_next = gap_inc;
            end
         end
         SEND: begin
            if (!bus.uart_busy_i) state_next = GUARD;
         end
         // The write strobe is issued here; the UART has not raised busy yet.
         GUARD: state_next = DRAIN;
         DRAIN: begin
            if (!bus.uart_busy_i) begin
`ifdef UART_ARB_TAG_EN
               if (tag_reg) begin
                  tag_next     = 1'b0;
                  gap_cnt_next = '0;
                  state_next   = FETCH;
               end else
`endif
               if (last_reg || burst_cnt_reg == 8'(MAX_BURST)) begin
                  grant_next  = '0;
                  rr_ptr_next = rot_ptr;
                  state_next  = IDLE;
               end else begin
                  gap_cnt_next = '0;
                  state_next   = FETCH;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
      if (!sys_rst_n_i) begin
         state_reg     <= IDLE;
         grant_reg     <= '0;
         idx_reg       <= '0;
         rr_ptr_reg    <= '0;
         burst_cnt_reg <= '0;
         gap_cnt_reg   <= '0;
         dat_reg       <= 8'h00;
         last_reg      <= 1'b0;
`ifdef UART_ARB_TAG_EN
         tag_reg       <= 1'b0;
`endif
      end else begin
         state_reg     <= state_next;
         grant_reg     <= grant_next;
         idx_reg       <= idx_next;
         rr_ptr_reg    <= rr_ptr_next;
         burst_cnt_reg <= burst_cnt_next;
         gap_cnt_reg   <= gap_cnt_next;
         dat_reg       <= dat_next;
         last_reg      <= last_next;
`ifdef UART_ARB_TAG_EN
         tag_reg       <= tag_next;
`endif
      end
   end

   assign bus.req_ready_o = (state_reg == FETCH) ? grant_reg : '0;
   assign bus.grant_o     = grant_reg;
   assign bus.uart_wr_o   = (state_reg == GUARD);
   assign bus.uart_dat_o  = dat_reg;
   assign bus.arb_busy_o  = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART (busy 1040 cycles after each write).
module tb_uart_tx_arbiter;

   localparam int N = 4;
`ifdef UART_ARB_TAG_EN
   localparam int TAGN = 1;
`else
   localparam int TAGN = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

   uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(16), .GAP_TIMEOUT(1023)) dut (
      .sys_clk_i   (clk),
      .sys_rst_n_i (rst_n),
      .bus         (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   logic [8:0] mem [N][64];
   int head [N];
   int tail [N];

   logic [N-1:0] log_gnt [256];
   logic [7:0]   log_dat [256];
   int           log_cyc [256];
   int           nlog = 0;

   logic [N-1:0] exp_gnt [64];
   logic [7:0]   exp_dat [64];
   int           nexp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Requester sources plus the UART model; samples mid-cycle, updates just after the edge.
   initial begin
      logic [N-1:0] hs;
      logic wr_s;
      int busy_cnt;
      int last_wr;
      bit have_wr;
      busy_cnt = 0;
      have_wr = 0;
      last_wr = 0;
      for (int k = 0; k < N; k++) begin head[k] = 0; end
      bus.req_valid_i = '0;
      bus.req_last_i  = '0;
      bus.req_data_i  = '0;
      bus.uart_busy_i = 1'b0;
      forever begin
         @(negedge clk);
         hs   = bus.req_valid_i & bus.req_ready_o;
         wr_s = bus.uart_wr_o;
         if (wr_s) begin
            log_gnt[nlog] = bus.grant_o;
            log_dat[nlog] = bus.uart_dat_o;
            log_cyc[nlog] = cyc;
            $display("[%0t] uart write %02h grant %b", $time, bus.uart_dat_o, bus.grant_o);
            chk("wr_while_busy", 32'(bus.uart_busy_i), 32'd0);
            if (have_wr) chk("wr_spacing_ge_1040", 32'((cyc - last_wr) >= 1040), 32'd1);
            have_wr = 1;
            last_wr = cyc;
            nlog++;
         end
         @(posedge clk);
         cyc++;
         #1;
         for (int k = 0; k < N; k++) begin
            if (hs[k]) head[k]++;
         end
         if (wr_s) busy_cnt = 1040;
         else if (busy_cnt > 0) busy_cnt--;
         bus.uart_busy_i = (busy_cnt != 0);
         for (int k = 0; k < N; k++) begin
            bus.req_valid_i[k]       = (head[k] < tail[k]);
            bus.req_last_i[k]        = mem[k][head[k]][8];
            bus.req_data_i[k*8 +: 8] = mem[k][head[k]][7:0];
         end
      end
   end

   task automatic push(input int k, input logic [7:0] d, input logic l);
      mem[k][tail[k]] = {l, d};
      tail[k]++;
   endtask

   task automatic add(input int k, input logic [7:0] d);
      exp_gnt[nexp] = N'(1) << k;
      exp_dat[nexp] = d;
      nexp++;
   endtask

   task automatic add_grant(input int k);
`ifdef UART_ARB_TAG_EN
      add(k, 8'hA0 | 8'(k));
`else
      if (k < 0) add(0, 8'h00);
`endif
   endtask

   function automatic bit all_empty();
      for (int k = 0; k < N; k++) if (head[k] != tail[k]) return 0;
      return 1;
   endfunction

   task automatic wait_done(input int budget);
      int n = 0;
      while (!(all_empty() && !bus.arb_busy_o && !bus.uart_busy_i) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("wait_done_in_budget", 32'(n < budget), 32'd1);
   endtask

   task automatic wait_log(input int target, input int budget);
      int n = 0;
      while (nlog < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("wait_log_in_budget", 32'(nlog >= target), 32'd1);
   endtask

   task automatic compare_log(input string name, input int base);
      chk($sformatf("%s_count", name), 32'(nlog - base), 32'(nexp));
      for (int i = 0; i < nexp && base + i < nlog; i++) begin
         chk($sformatf("%s_grant%0d", name, i), 32'(log_gnt[base+i]), 32'(exp_gnt[i]));
         chk($sformatf("%s_data%0d", name, i), 32'(log_dat[base+i]), 32'(exp_dat[i]));
      end
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_grant"}, 32'(bus.grant_o), 32'd0);
      chk({name, "_ready"}, 32'(bus.req_ready_o), 32'd0);
      chk({name, "_wr"}, 32'(bus.uart_wr_o), 32'd0);
      chk({name, "_arb_busy"}, 32'(bus.arb_busy_o), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      chk("reset_dat", 32'(bus.uart_dat_o), 32'h00);
      rst_n = 1'b1;
   endtask

   initial begin
      int base, start, n;
      for (int k = 0; k < N; k++) tail[k] = 0;

      // 1: single three-byte packet from req0, plus first-byte latency
      do_reset();
      @(negedge clk);
      base = nlog; nexp = 0; start = cyc + 1;
      push(0, 8'h11, 0); push(0, 8'h22, 0); push(0, 8'h33, 1);
      add_grant(0); add(0, 8'h11); add(0, 8'h22); add(0, 8'h33);
      repeat (2) @(negedge clk);
      chk("t1_grant", 32'(bus.grant_o), 32'b0001);
      wait_done(6000);
      chk("t1_first_wr_latency", 32'(log_cyc[base] - start), 32'd3);
      chk("t1_grant_after", 32'(bus.grant_o), 32'd0);
      compare_log("t1", base);

      // 2: all requesters valid with two-byte packets
      do_reset();
      @(negedge clk);
      base = nlog; nexp = 0;
      for (int k = 0; k < N; k++) begin
         push(k, 8'(16 * k + 1), 0); push(k, 8'(16 * k + 2), 1);
      end
      push(0, 8'h03, 0); push(0, 8'h04, 1);
      for (int k = 0; k < N; k++) begin
         add_grant(k); add(k, 8'(16 * k + 1)); add(k, 8'(16 * k + 2));
      end
      add_grant(0); add(0, 8'h03); add(0, 8'h04);
      wait_done(15000);
      compare_log("t2", base);

      // 3: req2 streams 20 bytes without last; forced rotation after 16
      do_reset();
      @(negedge clk);
      base = nlog; nexp = 0;
      for (int i = 1; i <= 20; i++) push(2, 8'(i), 0);
      n = 0;
      while (bus.grant_o !== 4'b0100 && n < 100) begin @(negedge clk); n++; end
      chk("t3_grant_req2", 32'(bus.grant_o), 32'b0100);
      push(0, 8'hE0, 1);
      add_grant(2);
      for (int i = 1; i <= 16; i++) add(2, 8'(i));
      add_grant(0); add(0, 8'hE0);
      add_grant(2);
      for (int i = 17; i <= 20; i++) add(2, 8'(i));
      wait_done(40000);
      chk("t3_grant_after_timeout", 32'(bus.grant_o), 32'd0);
      compare_log("t3", base);

      // 4: req1 goes silent after one byte; gap timeout hands over to req3
      do_reset();
      @(negedge clk);
      base = nlog; nexp = 0;
      push(1, 8'h55, 0);
      push(3, 8'h77, 1);
      add_grant(1); add(1, 8'h55); add_grant(3); add(3, 8'h77);
      wait_log(base + 1 + TAGN, 3000);
      n = 0;
      while (!bus.req_ready_o[1] && n < 3000) begin @(negedge clk); n++; end
      n = 0;
      while (bus.req_ready_o[1] && n < 3000) begin @(negedge clk); n++; end
      chk("t4_gap_cycles", 32'(n), 32'd1023);
      chk("t4_revoked", 32'(bus.grant_o), 32'd0);
      @(negedge clk);
      chk("t4_next_grant", 32'(bus.grant_o), 32'b1000);
      wait_done(6000);
      compare_log("t4", base);

      // 5: reset while draining; no write may follow until the UART is free
      do_reset();
      @(negedge clk);
      base = nlog; nexp = 0;
      push(0, 8'hAA, 0); push(0, 8'hBB, 1);
      add_grant(0); add(0, 8'hAA); add_grant(0); add(0, 8'hBB);
      wait_log(base + 1 + TAGN, 3000);
      repeat (10) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("t5_async");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("t5_no_wr_while_busy", 32'(bus.uart_wr_o), 32'd0);
      chk("t5_arb_stalled", 32'(bus.arb_busy_o), 32'd1);
      chk("t5_regrant", 32'(bus.grant_o), 32'b0001);
      wait_done(6000);
      compare_log("t5", base);

      // 6: one-byte packet from req3 (tag precedes it when tagging is built in)
      @(negedge clk);
      base = nlog; nexp = 0;
      push(3, 8'h5A, 1);
      add_grant(3); add(3, 8'h5A);
      wait_done(6000);
      compare_log("t6", base);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
